// File: rtl/kv_stream_buffer_pkg.sv
// Shared types for the K/V stream buffers: vector type, FSM state encoding
// and the default sequence length.
package kv_stream_buffer_pkg;

    localparam int MAX_SEQ_LENGTH = 8;
    localparam int VEC_W          = 32;

    typedef logic [VEC_W-1:0] K_VECTOR_T;
    typedef K_VECTOR_T        V_VECTOR_T;

    typedef enum logic [1:0] {
        KB_FILL   = 2'd0,
        KB_STREAM = 2'd1,
        KB_DONE   = 2'd2
    } kb_state_e;

endpackage

// File: rtl/kv_vector_store.sv
// DEPTH-entry register array with one synchronous write port and one
// combinational read port; contents are deliberately not reset.
module kv_vector_store
    import kv_stream_buffer_pkg::*;
#(
    parameter int DEPTH = MAX_SEQ_LENGTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  K_VECTOR_T     wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output K_VECTOR_T     rd_data_o
);

    K_VECTOR_T mem_q [DEPTH];

    // Address decode by explicit compare keeps non-power-of-two depths safe.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_addr_i == AW'(i))) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_i == AW'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/kv_stream_buffer.sv
// Captures DEPTH vectors from the memory controller, then replays the whole
// set NUM_PASSES times to the attention datapath before signalling done.
module kv_stream_buffer
    import kv_stream_buffer_pkg::*;
#(
    parameter int DEPTH      = MAX_SEQ_LENGTH,
    parameter int NUM_PASSES = MAX_SEQ_LENGTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_vld,
    output logic                            in_rdy,
    input  K_VECTOR_T                       in_vector,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output K_VECTOR_T                       out_vector,
    output logic                            out_last,
    output logic [$clog2(NUM_PASSES+1)-1:0] pass_idx,
    output logic                            done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(NUM_PASSES + 1);

    kb_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic          wr_en;
    K_VECTOR_T     rd_data;

    kv_vector_store #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_vector),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= KB_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // Handshake outputs depend on state only; pass_cnt runs to NUM_PASSES.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
        wr_en      = 1'b0;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        out_vector = '0;
        out_last   = 1'b0;
        done       = 1'b0;

        case (state_q)
            KB_FILL: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == PW'(DEPTH - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = KB_STREAM;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            KB_STREAM: begin
                out_vld    = 1'b1;
                out_vector = rd_data;
                out_last   = (rd_ptr_q == PW'(DEPTH - 1));
                if (out_rdy) begin
                    if (out_last) begin
                        rd_ptr_d   = '0;
                        pass_cnt_d = pass_cnt_q + 1'b1;
                        if (pass_cnt_q == CW'(NUM_PASSES - 1)) begin
                            state_d = KB_DONE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            KB_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = KB_FILL;
            end
        endcase
    end

    assign pass_idx = pass_cnt_q;

endmodule

// File: tb/tb_kv_stream_buffer.sv
// Scoreboard bench for kv_stream_buffer: a queue-based reference model predicts
// the replay stream, plus directed checks of the DEPTH=1 and DEPTH=3 corners.
module tb_kv_stream_buffer;
    import kv_stream_buffer_pkg::*;

    localparam int D = 4;
    localparam int P = 2;

    typedef struct {
        logic [31:0] vec;
        int          last;
        int          pass;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;

    // Main instance, DEPTH=4 / NUM_PASSES=2
    logic       inVld = 1'b0;
    logic       inRdy;
    K_VECTOR_T  inVector = '0;
    logic       outVld;
    logic       outRdy = 1'b0;
    K_VECTOR_T  outVector;
    logic       outLast;
    logic [1:0] passIdx;
    logic       done;

    // Edge instance, DEPTH=1 / NUM_PASSES=1
    logic       e1InVld = 1'b0;
    logic       e1InRdy;
    K_VECTOR_T  e1InVec = '0;
    logic       e1OutVld;
    logic       e1OutRdy = 1'b0;
    K_VECTOR_T  e1OutVec;
    logic       e1OutLast;
    logic [0:0] e1PassIdx;
    logic       e1Done;

    // Edge instance, DEPTH=3 / NUM_PASSES=2
    logic       e3InVld = 1'b0;
    logic       e3InRdy;
    K_VECTOR_T  e3InVec = '0;
    logic       e3OutVld;
    logic       e3OutRdy = 1'b0;
    K_VECTOR_T  e3OutVec;
    logic       e3OutLast;
    logic [1:0] e3PassIdx;
    logic       e3Done;

    int checks   = 0;
    int failures = 0;

    // Reference model state: vectors accepted so far and vectors consumed.
    int          fillCnt = 0;
    int          outCnt  = 0;
    logic [31:0] mdlMem [D];
    exp_t        expQ [$];

    always #5 clk = ~clk;

    kv_stream_buffer #(.DEPTH(D), .NUM_PASSES(P)) dut (
        .clk(clk), .rst(rst),
        .in_vld(inVld), .in_rdy(inRdy), .in_vector(inVector),
        .out_vld(outVld), .out_rdy(outRdy), .out_vector(outVector),
        .out_last(outLast), .pass_idx(passIdx), .done(done)
    );

    kv_stream_buffer #(.DEPTH(1), .NUM_PASSES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_vld(e1InVld), .in_rdy(e1InRdy), .in_vector(e1InVec),
        .out_vld(e1OutVld), .out_rdy(e1OutRdy), .out_vector(e1OutVec),
        .out_last(e1OutLast), .pass_idx(e1PassIdx), .done(e1Done)
    );

    kv_stream_buffer #(.DEPTH(3), .NUM_PASSES(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_vld(e3InVld), .in_rdy(e3InRdy), .in_vector(e3InVec),
        .out_vld(e3OutVld), .out_rdy(e3OutRdy), .out_vector(e3OutVec),
        .out_last(e3OutLast), .pass_idx(e3PassIdx), .done(e3Done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit modelStreaming();
        return (fillCnt == D) && (outCnt < D * P);
    endfunction

    // One clock of stimulus, level checks against the model, then model update.
    task automatic applyStimulus(input bit vld, input logic [31:0] vec,
                                 input bit ordy, input bit r);
        @(posedge clk);
        #1;
        rst      = r;
        inVld    = vld;
        inVector = vec;
        outRdy   = ordy;
        @(negedge clk);
        checkOutput("in_rdy", 32'(inRdy), 32'(fillCnt < D));
        checkOutput("out_vld", 32'(outVld), 32'(modelStreaming()));
        checkOutput("done", 32'(done), 32'(outCnt == D * P));
        checkOutput("pass_idx", 32'(passIdx), (fillCnt < D) ? 32'd0 : 32'(outCnt / D));
        if (!modelStreaming()) begin
            checkOutput("idle_vector", outVector, 32'd0);
            checkOutput("idle_last", 32'(outLast), 32'd0);
        end
        if (r) begin
            fillCnt = 0;
            outCnt  = 0;
            expQ.delete();
        end else if (fillCnt < D) begin
            if (vld) begin
                mdlMem[fillCnt] = vec;
                fillCnt++;
                if (fillCnt == D) begin
                    for (int p = 0; p < P; p++) begin
                        for (int k = 0; k < D; k++) begin
                            expQ.push_back('{vec: mdlMem[k], last: int'(k == D - 1), pass: p});
                        end
                    end
                end
            end
        end else if (modelStreaming() && ordy) begin
            outCnt++;
        end
    endtask

    // vldMode: 0 continuous, 1 every third cycle, 2 random.
    // rdyPct < 0 selects the repeating 1,0,0,1 backpressure pattern.
    task automatic runUntilDone(input int vldMode, input int rdyPct, input int limit);
        bit vld;
        bit ordy;
        for (int i = 0; i < limit && outCnt != D * P; i++) begin
            case (vldMode)
                0:       vld = 1'b1;
                1:       vld = (i % 3 == 0);
                default: vld = $urandom_range(1);
            endcase
            if (rdyPct < 0) ordy = (i % 4 == 0) || (i % 4 == 3);
            else            ordy = ($urandom_range(99) < rdyPct);
            applyStimulus(vld, $urandom, ordy, 1'b0);
        end
        checkOutput("run_bound", 32'(outCnt == D * P), 32'd1);
        applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard monitor: pops on every output handshake, checks hold on stalls.
    always @(negedge clk) begin
        if (!rst && outVld) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_out", 32'd1, 32'd0);
            end else if (outRdy) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_vector", outVector, e.vec);
                checkOutput("out_last", 32'(outLast), 32'(e.last));
                checkOutput("out_pass", 32'(passIdx), 32'(e.pass));
            end else begin
                checkOutput("stall_hold", outVector, expQ[0].vec);
            end
        end
    end

    logic [31:0] e3Exp [3];

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Directed fill A0..A3 with continuous valid and ready
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
        end
        runUntilDone(0, 100, 40);

        // Backpressure pattern 1,0,0,1 with gapped input
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        runUntilDone(1, -1, 120);

        // Reset during pass 1 at read index 2, then refill B0..B3
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        end
        for (int i = 0; i < 40 && outCnt < D + 2; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        end
        runUntilDone(2, 70, 80);

        // Random runs
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
            runUntilDone(2, 30 + $urandom_range(70), 200);
        end

        // DEPTH=1, NUM_PASSES=1: single output with out_last, then done
        @(posedge clk);
        #1;
        e1InVld  = 1'b1;
        e1InVec  = 32'h5A5A0001;
        e1OutRdy = 1'b1;
        @(negedge clk);
        checkOutput("e1_in_rdy", 32'(e1InRdy), 32'd1);
        checkOutput("e1_fill_out_vld", 32'(e1OutVld), 32'd0);
        @(posedge clk);
        #1;
        e1InVld = 1'b0;
        @(negedge clk);
        checkOutput("e1_out_vld", 32'(e1OutVld), 32'd1);
        checkOutput("e1_out_vector", e1OutVec, 32'h5A5A0001);
        checkOutput("e1_out_last", 32'(e1OutLast), 32'd1);
        checkOutput("e1_pass_idx", 32'(e1PassIdx), 32'd0);
        checkOutput("e1_in_rdy_stream", 32'(e1InRdy), 32'd0);
        @(negedge clk);
        checkOutput("e1_done", 32'(e1Done), 32'd1);
        checkOutput("e1_done_out_vld", 32'(e1OutVld), 32'd0);
        checkOutput("e1_done_pass_idx", 32'(e1PassIdx), 32'd1);
        checkOutput("e1_done_vector", e1OutVec, 32'd0);

        // DEPTH=3, NUM_PASSES=2: read index wraps 2 -> 0 between passes
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            e3Exp[i] = $urandom;
            e3InVld  = 1'b1;
            e3InVec  = e3Exp[i];
            e3OutRdy = 1'b1;
            @(negedge clk);
            checkOutput("e3_in_rdy", 32'(e3InRdy), 32'd1);
            checkOutput("e3_fill_out_vld", 32'(e3OutVld), 32'd0);
        end
        @(posedge clk);
        #1;
        e3InVld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("e3_out_vld", 32'(e3OutVld), 32'd1);
            checkOutput("e3_out_vector", e3OutVec, e3Exp[k % 3]);
            checkOutput("e3_out_last", 32'(e3OutLast), 32'(k % 3 == 2));
            checkOutput("e3_pass_idx", 32'(e3PassIdx), 32'(k / 3));
        end
        @(negedge clk);
        checkOutput("e3_done", 32'(e3Done), 32'd1);
        checkOutput("e3_done_pass_idx", 32'(e3PassIdx), 32'd2);
        checkOutput("e3_done_out_vld", 32'(e3OutVld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
